// File: rtl/tick_feed_tx.sv
// Byte-serial tick reassembler with a small FIFO and paced strobe output
// toward the strategy engines.
module tick_feed_tx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 3,
    parameter int BYTE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        feed_en,
    output logic [15:0] data_out,
    output logic        enable_out,
    output logic        fifo_full,
    output logic        overflow,
    output logic        frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t state, state_next;

    logic [7:0]    hi;
    logic [TW-1:0] timer;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [GW-1:0] gap;

    logic lo_seen, timeout, empty, pop, push;

    assign lo_seen   = (state == WAIT_LO) && byte_valid;
    assign timeout   = (state == WAIT_LO) && !byte_valid
                       && (timer == TW'(BYTE_TIMEOUT - 1));
    assign empty     = (count == '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = !empty && feed_en && (gap == '0);
    // A full FIFO still accepts a tick when a pop frees a slot this cycle
    assign push      = lo_seen && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HI;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_HI: if (byte_valid) state_next = WAIT_LO;
            WAIT_LO: if (byte_valid || timeout) state_next = WAIT_HI;
            default: state_next = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi        <= '0;
            timer     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= timeout;
            if (state == WAIT_HI && byte_valid) begin
                hi    <= byte_in;
                timer <= '0;
            end else if (state == WAIT_LO && !byte_valid && !timeout) begin
                timer <= timer + TW'(1);
            end
            if (lo_seen && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {hi, byte_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            enable_out <= 1'b0;
            gap        <= '0;
        end else if (pop) begin
            data_out   <= mem[rd_ptr];
            enable_out <= 1'b1;
            gap        <= GW'(GAP_CYCLES);
        end else begin
            enable_out <= 1'b0;
            if (gap != '0) gap <= gap - GW'(1);
        end
    end

endmodule

// File: tb/tb_tick_feed_tx.sv
// Directed bench for tick_feed_tx: latency, pacing, overflow, timeout,
// reset and full-FIFO push/pop collision.
module tb_tick_feed_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        feed_en = 1'b1;
    logic [15:0] data_out;
    logic        enable_out;
    logic        fifo_full;
    logic        overflow;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] pd[$];
    int          pc[$];

    tick_feed_tx #(
        .FIFO_DEPTH(4),
        .GAP_CYCLES(3),
        .BYTE_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .feed_en(feed_en),
        .data_out(data_out),
        .enable_out(enable_out),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && enable_out) begin
            pd.push_back(data_out);
            pc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        step(1);
        byte_valid = 1'b0;
    endtask

    task automatic send_tick(input logic [15:0] w);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic clear_q();
        pd.delete();
        pc.delete();
    endtask

    logic [15:0] t2 [4];
    logic [15:0] t3 [5];

    initial begin
        t2[0] = 16'hC2EE; t2[1] = 16'h44E2; t2[2] = 16'h896C; t2[3] = 16'h2A94;
        t3[0] = 16'h0101; t3[1] = 16'h4202; t3[2] = 16'h8303;
        t3[3] = 16'hC404; t3[4] = 16'h1505;

        step(2);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_en", 32'(enable_out), 32'h0);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // 1: single tick, 2-cycle latency
        send(8'h2A);
        send(8'h94);
        chk("t1_en_n", 32'(enable_out), 32'h0);
        step(1);
        chk("t1_en", 32'(enable_out), 32'h1);
        chk("t1_data", 32'(data_out), 32'h2A94);
        step(1);
        chk("t1_en_off", 32'(enable_out), 32'h0);
        chk("t1_hold", 32'(data_out), 32'h2A94);
        step(6);

        // 2: four back-to-back ticks, paced 4 cycles apart
        clear_q();
        for (int i = 0; i < 4; i++) send_tick(t2[i]);
        step(30);
        chk("t2_cnt", 32'(pd.size()), 32'd4);
        if (pd.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_data", 32'(pd[i]), 32'(t2[i]));
            for (int i = 1; i < 4; i++) chk("t2_space", 32'(pc[i] - pc[i-1]), 32'd4);
        end

        // 3: hold, fill, overflow on fifth tick
        feed_en = 1'b0;
        clear_q();
        for (int i = 0; i < 3; i++) send_tick(t3[i]);
        chk("t3_notfull", 32'(fifo_full), 32'h0);
        send_tick(t3[3]);
        chk("t3_full", 32'(fifo_full), 32'h1);
        chk("t3_ovf0", 32'(overflow), 32'h0);
        send_tick(t3[4]);
        chk("t3_ovf1", 32'(overflow), 32'h1);
        chk("t3_nopulse", 32'(pd.size()), 32'd0);
        feed_en = 1'b1;
        step(30);
        chk("t3_cnt", 32'(pd.size()), 32'd4);
        if (pd.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_data", 32'(pd[i]), 32'(t3[i]));
        chk("t3_sticky", 32'(overflow), 32'h1);
        chk("t3_empty_full", 32'(fifo_full), 32'h0);

        // 4: hi byte then silence -> timeout
        clear_q();
        send(8'h55);
        begin
            int early = 0;
            for (int i = 0; i < 254; i++) begin
                step(1);
                if (frame_err) early++;
            end
            chk("t4_early", 32'(early), 32'd0);
        end
        step(1);
        chk("t4_ferr", 32'(frame_err), 32'h1);
        step(1);
        chk("t4_ferr_off", 32'(frame_err), 32'h0);
        send_tick(16'hC2EE);
        step(6);
        chk("t4_cnt", 32'(pd.size()), 32'd1);
        if (pd.size() == 1) chk("t4_data", 32'(pd[0]), 32'hC2EE);

        // 5: asynchronous reset with ticks queued and hi byte latched
        feed_en = 1'b0;
        for (int i = 0; i < 3; i++) send_tick(t2[i]);
        send(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_data", 32'(data_out), 32'h0);
        chk("t5_en", 32'(enable_out), 32'h0);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_full", 32'(fifo_full), 32'h0);
        chk("t5_ferr", 32'(frame_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        feed_en = 1'b1;
        clear_q();
        step(20);
        chk("t5_nopulse", 32'(pd.size()), 32'd0);
        send_tick(16'h1234);
        step(4);
        chk("t5_new_cnt", 32'(pd.size()), 32'd1);
        if (pd.size() == 1) chk("t5_new", 32'(pd[0]), 32'h1234);
        step(6);

        // 6: lo byte lands on the pop cycle of a full FIFO
        feed_en = 1'b0;
        clear_q();
        for (int i = 0; i < 4; i++) send_tick(t3[i]);
        chk("t6_full", 32'(fifo_full), 32'h1);
        send(8'hAB);
        feed_en = 1'b1;
        send(8'hCD);
        chk("t6_stillfull", 32'(fifo_full), 32'h1);
        chk("t6_ovf", 32'(overflow), 32'h0);
        step(30);
        chk("t6_cnt", 32'(pd.size()), 32'd5);
        if (pd.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("t6_data", 32'(pd[i]), 32'(t3[i]));
            chk("t6_last", 32'(pd[4]), 32'hABCD);
        end
        chk("t6_ovf_end", 32'(overflow), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
